// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard.
//   stage_rec_t : shadow destination record kept per post-decode stage
//   FWD_RF      : forwarding select value meaning "use the register file"
//   CP0_EPC     : CP0 register number of EPC
//   AW_DEF/TW_DEF : default register-address and Tuse/Tnew widths; the
//                   record fields are sized by these, so the scoreboard's
//                   AW/TW parameters must not exceed them.
//   age_rec()   : one-stage advance of a record (Tnew counts down to 0)
// Optional feature macro: HAZARD_EPC_INTERLOCK_EN adds the per-record epc bit.
package hazard_pkg;

  localparam int AW_DEF = 5;
  localparam int TW_DEF = 2;
  localparam int FWD_RF = 0;
  localparam logic [4:0] CP0_EPC = 5'd14;

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [AW_DEF-1:0] wa;
    logic [TW_DEF-1:0] tnew;
    logic [AW_DEF-1:0] rs;
    logic [AW_DEF-1:0] rt;
`ifdef HAZARD_EPC_INTERLOCK_EN
    logic              epc;
`endif
  } stage_rec_t;

  // A record moving one stage down the pipe is one cycle closer to
  // having its result available.
  function automatic stage_rec_t age_rec(input stage_rec_t r);
    stage_rec_t a;
    a = r;
    if (a.tnew != '0) a.tnew = a.tnew - 1'b1;
    return a;
  endfunction

endpackage

// File: rtl/hz_youngest_match.sv
// hz_youngest_match: priority finder over the stage records.
// Finds the youngest (lowest-numbered) stage k >= MIN_STAGE whose record
// writes the register 'addr' (register 0 never matches).
//   recs : stage records 1..NSTAGE
//   addr : register being looked up
//   hit  : a matching record exists
//   idx  : stage number of the youngest match (0 when no hit)
//   tnew : remaining Tnew of that record (0 when no hit)
// Optional feature macro: HAZARD_EPC_INTERLOCK_EN (record layout only).
module hz_youngest_match
  import hazard_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int MIN_STAGE = 1,
  localparam int SW = $clog2(NSTAGE + 1)
) (
  input  stage_rec_t        recs [1:NSTAGE],
  input  logic [AW_DEF-1:0] addr,
  output logic              hit,
  output logic [SW-1:0]     idx,
  output logic [TW_DEF-1:0] tnew
);

  // Scan from the oldest stage toward the youngest so the last hit written
  // is the youngest one.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    tnew = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (k >= MIN_STAGE && recs[k].valid && recs[k].wen &&
          recs[k].wa == addr && addr != '0) begin
        hit  = 1'b1;
        idx  = SW'(k);
        tnew = recs[k].tnew;
      end
    end
  end

  // Source-register fields travel with the record but are not looked at here.
  logic unused_fields;
  always_comb begin
    unused_fields = 1'b0;
    for (int k = 1; k <= NSTAGE; k++) begin
      unused_fields = unused_fields ^ (^recs[k].rs) ^ (^recs[k].rt);
`ifdef HAZARD_EPC_INTERLOCK_EN
      unused_fields = unused_fields ^ recs[k].epc;
`endif
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-side hazard unit for the in-order MIPS core.
// Keeps a shadow record of every in-flight instruction past decode plus an
// MDU busy countdown, and derives the decode stall and the forwarding
// selects for the D, E and M consumers.
//   clk, rst_n          : clock, asynchronous active-low reset
//   d_*                 : decode-slot instruction attributes
//   flush               : clear every post-decode record this edge
//   stall               : freeze F/D, inject a bubble into E
//   fwd_d_rs/rt         : D-stage source selects (0 = RF, k = stage k)
//   fwd_e_rs/rt         : E-stage operand selects (0 or 2..NSTAGE)
//   fwd_m_rt            : M-stage store-data select (0 or 3..NSTAGE)
//   mdu_busy            : MDU countdown nonzero
// Optional feature macro: HAZARD_EPC_INTERLOCK_EN -- when defined, eret is
// held in decode while an mtc0-to-EPC is still in flight; when undefined,
// d_eret and d_mtc0_epc are ignored.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE  = 3,
  parameter int AW      = AW_DEF,
  parameter int TW      = TW_DEF,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  localparam int SW = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_wen,
  input  logic [AW-1:0] d_wa,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_mdu_start,
  input  logic          d_mdu_div,
  input  logic          d_mdu_related,
  input  logic          d_eret,
  input  logic          d_mtc0_epc,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_d_rs,
  output logic [SW-1:0] fwd_d_rt,
  output logic [SW-1:0] fwd_e_rs,
  output logic [SW-1:0] fwd_e_rt,
  output logic [SW-1:0] fwd_m_rt,
  output logic          mdu_busy
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);

  stage_rec_t        rec [1:NSTAGE];
  stage_rec_t        d_rec;
  logic [CW-1:0]     mdu_cnt;
  logic              issue;

  // Decode instruction packaged as the record it becomes in stage 1.
  always_comb begin
    d_rec       = '0;
    d_rec.valid = 1'b1;
    d_rec.wen   = d_wen;
    d_rec.wa    = AW_DEF'(d_wa);
    d_rec.tnew  = TW_DEF'(d_tnew);
    d_rec.rs    = AW_DEF'(d_rs);
    d_rec.rt    = AW_DEF'(d_rt);
`ifdef HAZARD_EPC_INTERLOCK_EN
    d_rec.epc   = d_mtc0_epc;
`endif
  end

  // The decode instruction moves into stage 1 only when it is real, not
  // held by a stall, and not killed by a flush.
  assign issue = d_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= NSTAGE; k++) rec[k] <= '0;
    end else if (flush) begin
      for (int k = 1; k <= NSTAGE; k++) rec[k] <= '0;
    end else begin
      rec[1] <= issue ? d_rec : '0;
      for (int k = 2; k <= NSTAGE; k++) rec[k] <= age_rec(rec[k-1]);
    end
  end

  // MDU countdown: a flush does not cancel an op already issued, but a
  // start killed by the flush never loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= '0;
    end else if (issue && d_mdu_start) begin
      mdu_cnt <= d_mdu_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (mdu_cnt != '0) begin
      mdu_cnt <= mdu_cnt - 1'b1;
    end
  end

  assign mdu_busy = (mdu_cnt != '0);

  // Youngest-writer lookups for each consumer.
  logic              hit_drs, hit_drt, hit_ers, hit_ert, hit_mrt;
  logic [SW-1:0]     idx_drs, idx_drt, idx_ers, idx_ert, idx_mrt;
  logic [TW_DEF-1:0] tn_drs, tn_drt, tn_ers, tn_ert, tn_mrt;
  logic [AW_DEF-1:0] m_rt;

  if (NSTAGE >= 2) begin : g_m_addr
    assign m_rt = rec[2].rt;
  end else begin : g_m_none
    assign m_rt = '0;
  end

  hz_youngest_match #(.NSTAGE(NSTAGE), .MIN_STAGE(1)) u_match_d_rs (
    .recs(rec), .addr(AW_DEF'(d_rs)), .hit(hit_drs), .idx(idx_drs), .tnew(tn_drs));
  hz_youngest_match #(.NSTAGE(NSTAGE), .MIN_STAGE(1)) u_match_d_rt (
    .recs(rec), .addr(AW_DEF'(d_rt)), .hit(hit_drt), .idx(idx_drt), .tnew(tn_drt));
  hz_youngest_match #(.NSTAGE(NSTAGE), .MIN_STAGE(2)) u_match_e_rs (
    .recs(rec), .addr(rec[1].rs), .hit(hit_ers), .idx(idx_ers), .tnew(tn_ers));
  hz_youngest_match #(.NSTAGE(NSTAGE), .MIN_STAGE(2)) u_match_e_rt (
    .recs(rec), .addr(rec[1].rt), .hit(hit_ert), .idx(idx_ert), .tnew(tn_ert));
  hz_youngest_match #(.NSTAGE(NSTAGE), .MIN_STAGE(3)) u_match_m_rt (
    .recs(rec), .addr(m_rt), .hit(hit_mrt), .idx(idx_mrt), .tnew(tn_mrt));

  // Forward only from the youngest writer, and only once its result exists;
  // an older ready writer holds a stale value.
  assign fwd_d_rs = (hit_drs && tn_drs == '0) ? idx_drs : SW'(FWD_RF);
  assign fwd_d_rt = (hit_drt && tn_drt == '0) ? idx_drt : SW'(FWD_RF);
  assign fwd_e_rs = (hit_ers && tn_ers == '0) ? idx_ers : SW'(FWD_RF);
  assign fwd_e_rt = (hit_ert && tn_ert == '0) ? idx_ert : SW'(FWD_RF);
  assign fwd_m_rt = (hit_mrt && tn_mrt == '0) ? idx_mrt : SW'(FWD_RF);

  logic rs_stall, rt_stall, mdu_stall, epc_stall;

  assign rs_stall  = hit_drs && (tn_drs > TW_DEF'(d_tuse_rs));
  assign rt_stall  = hit_drt && (tn_drt > TW_DEF'(d_tuse_rt));
  assign mdu_stall = d_mdu_related & mdu_busy;

`ifdef HAZARD_EPC_INTERLOCK_EN
  logic epc_pending;
  always_comb begin
    epc_pending = 1'b0;
    for (int k = 1; k <= NSTAGE; k++) begin
      if (rec[k].valid && rec[k].epc) epc_pending = 1'b1;
    end
  end
  assign epc_stall = d_eret & epc_pending;
`else
  assign epc_stall = 1'b0;
  logic unused_epc_in;
  assign unused_epc_in = d_eret ^ d_mtc0_epc;
`endif

  assign stall = d_valid & (rs_stall | rt_stall | mdu_stall | epc_stall);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed bench for hazard_scoreboard with
// hand-derived expected stall / forward / busy values.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_wen, d_mdu_start, d_mdu_div, d_mdu_related, d_eret, d_mtc0_epc;
  logic       flush;
  logic       stall, mdu_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

`ifdef HAZARD_EPC_INTERLOCK_EN
  localparam int EXP_EPC_STALLS = 3;
`else
  localparam int EXP_EPC_STALLS = 0;
`endif

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wen(d_wen), .d_wa(d_wa),
    .d_tnew(d_tnew), .d_mdu_start(d_mdu_start), .d_mdu_div(d_mdu_div),
    .d_mdu_related(d_mdu_related), .d_eret(d_eret), .d_mtc0_epc(d_mtc0_epc),
    .flush(flush), .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
    .mdu_busy(mdu_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic d_idle();
    d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0;
    d_wen = 0; d_wa = 0; d_tnew = 0; d_mdu_start = 0; d_mdu_div = 0;
    d_mdu_related = 0; d_eret = 0; d_mtc0_epc = 0;
  endtask

  task automatic d_op(input logic wen, input logic [4:0] wa, input logic [1:0] tnew,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] tu_rs, input logic [1:0] tu_rt);
    d_idle();
    d_valid = 1; d_wen = wen; d_wa = wa; d_tnew = tnew;
    d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
  endtask

  task automatic drain();
    d_idle();
    repeat (4) tick();
  endtask

  // MDU op followed by a dependent mfhi; counts the busy/stall cycles.
  task automatic mdu_run(input logic is_div, input int exp_cycles, input string tag);
    d_idle(); d_valid = 1; d_mdu_start = 1; d_mdu_div = is_div; d_mdu_related = 1;
    settle();
    check({tag, "_start_nostall"}, stall, 0);
    tick();
    d_op(1, 5'd2, 2'd1, 0, 0, 2'd1, 2'd1); d_mdu_related = 1;
    settle();
    n = 0;
    while (mdu_busy && n < 20) begin
      check({tag, "_mfhi_stall"}, stall, 1);
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, exp_cycles);
    check({tag, "_mfhi_release"}, stall, 0);
    tick();
    d_idle(); settle();
    check({tag, "_mfhi_no_restart"}, mdu_busy, 0);
    drain();
  endtask

  initial begin
    rst_n = 0; flush = 0; d_idle();
    #2;
    check("rst_stall", stall, 0);
    check("rst_mdu_busy", mdu_busy, 0);
    check("rst_fwd_d_rs", fwd_d_rs, 0);
    check("rst_fwd_d_rt", fwd_d_rt, 0);
    check("rst_fwd_e_rs", fwd_e_rs, 0);
    check("rst_fwd_e_rt", fwd_e_rt, 0);
    check("rst_fwd_m_rt", fwd_m_rt, 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1;
    tick();

    // Load-use: lw $1 (tnew 2) then addu $2,$1,$0 (tuse 1).
    // Stage 1 tnew 2 > 1 -> one stall; then lw sits in stage 2 with tnew 1,
    // not yet forwardable to D; once addu is in E the lw is in stage 3.
    d_op(1, 5'd1, 2'd2, 0, 0, 2'd1, 2'd1); settle();
    check("lu_lw_nostall", stall, 0);
    tick();
    d_op(1, 5'd2, 2'd1, 5'd1, 0, 2'd1, 2'd1); settle();
    check("lu_stall", stall, 1);
    check("lu_fwd_d_wait", fwd_d_rs, 0);
    tick(); settle();
    check("lu_release", stall, 0);
    check("lu_fwd_d_rs", fwd_d_rs, 0);
    tick(); d_idle(); settle();
    check("lu_fwd_e_rs", fwd_e_rs, 3);
    check("lu_fwd_e_rt", fwd_e_rt, 0);
    drain();

    // ALU chain: addu $3 (tnew 1) then beq $3 (tuse 0).
    d_op(1, 5'd3, 2'd1, 0, 0, 2'd1, 2'd1); tick();
    d_op(0, 0, 2'd0, 5'd3, 0, 2'd0, 2'd0); settle();
    check("alu_stall", stall, 1);
    tick(); settle();
    check("alu_release", stall, 0);
    check("alu_fwd_d_rs", fwd_d_rs, 2);
    tick();
    d_op(0, 0, 2'd0, 0, 5'd3, 2'd1, 2'd2); settle();
    check("alu_sw_fwd_d_rt", fwd_d_rt, 3);
    check("alu_sw_nostall", stall, 0);
    drain();

    // Store data: addu $3 then sw $3 straight behind it; rt tracked to M.
    d_op(1, 5'd3, 2'd1, 0, 0, 2'd1, 2'd1); tick();
    d_op(0, 0, 2'd0, 0, 5'd3, 2'd1, 2'd2); settle();
    check("st_nostall", stall, 0);
    check("st_fwd_d_rt_wait", fwd_d_rt, 0);
    tick(); d_idle(); settle();
    check("st_fwd_e_rt", fwd_e_rt, 2);
    tick(); settle();
    check("st_fwd_m_rt", fwd_m_rt, 3);
    check("st_fwd_e_rt_bubble", fwd_e_rt, 0);
    drain();

    // Writes to $0 never match.
    d_op(1, 5'd0, 2'd1, 0, 0, 2'd1, 2'd1); tick();
    d_op(0, 0, 2'd0, 5'd0, 5'd0, 2'd0, 2'd0); settle();
    check("r0_nostall", stall, 0);
    check("r0_fwd_d_rs", fwd_d_rs, 0);
    drain();

    // Two ready writers of $5 in stages 1 and 2: the youngest is selected.
    d_op(1, 5'd5, 2'd0, 0, 0, 2'd1, 2'd1); tick();
    d_op(1, 5'd5, 2'd0, 0, 0, 2'd1, 2'd1); tick();
    d_op(0, 0, 2'd0, 5'd5, 5'd5, 2'd0, 2'd0); settle();
    check("yw_fwd_d_rs", fwd_d_rs, 1);
    check("yw_fwd_d_rt", fwd_d_rt, 1);
    check("yw_nostall", stall, 0);
    tick(); d_idle(); settle();
    check("yw_fwd_e_rs", fwd_e_rs, 2);
    drain();

    // Older slow writer (lw $6, now tnew 1) behind a younger ready writer:
    // the older match is ignored, so no stall and stage 1 is selected.
    d_op(1, 5'd6, 2'd2, 0, 0, 2'd1, 2'd1); tick();
    d_op(1, 5'd6, 2'd0, 0, 0, 2'd1, 2'd1); tick();
    d_op(0, 0, 2'd0, 5'd6, 0, 2'd0, 2'd0); settle();
    check("old_ignored_nostall", stall, 0);
    check("old_ignored_fwd", fwd_d_rs, 1);
    drain();

    // MDU countdown for divide and multiply.
    mdu_run(1'b1, 10, "div");
    mdu_run(1'b0, 5, "mul");

    // Flush with three valid records, mult issued in the flush cycle.
    d_op(1, 5'd6, 2'd0, 0, 0, 2'd1, 2'd1); tick();
    d_op(1, 5'd7, 2'd0, 0, 0, 2'd1, 2'd1); tick();
    d_op(1, 5'd8, 2'd0, 0, 0, 2'd1, 2'd1); tick();
    d_op(0, 0, 2'd0, 5'd6, 5'd7, 2'd0, 2'd0); settle();
    check("pre_flush_fwd_d_rs", fwd_d_rs, 3);
    check("pre_flush_fwd_d_rt", fwd_d_rt, 2);
    d_idle(); d_valid = 1; d_mdu_start = 1; d_mdu_related = 1; flush = 1; settle();
    check("flush_mult_nostall", stall, 0);
    tick();
    flush = 0;
    d_op(0, 0, 2'd0, 5'd6, 5'd8, 2'd0, 2'd0); settle();
    check("post_flush_fwd_d_rs", fwd_d_rs, 0);
    check("post_flush_fwd_d_rt", fwd_d_rt, 0);
    check("post_flush_stall", stall, 0);
    check("post_flush_mdu_busy", mdu_busy, 0);
    drain();

    // mtc0 EPC followed by eret.
    d_idle(); d_valid = 1; d_mtc0_epc = 1; tick();
    d_idle(); d_valid = 1; d_eret = 1; settle();
    n = 0;
    while (stall && n < 10) begin
      n++;
      tick();
    end
    check("eret_stall_cycles", n, EXP_EPC_STALLS);
    drain();

    // Asynchronous reset in mid-operation drops records and the countdown.
    d_idle(); d_valid = 1; d_mdu_start = 1; d_mdu_related = 1; tick();
    d_op(1, 5'd9, 2'd0, 0, 0, 2'd1, 2'd1); tick();
    d_op(0, 0, 2'd0, 5'd9, 0, 2'd0, 2'd0); settle();
    check("pre_rst_fwd_d_rs", fwd_d_rs, 1);
    check("pre_rst_mdu_busy", mdu_busy, 1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_fwd_d_rs", fwd_d_rs, 0);
    check("mid_rst_mdu_busy", mdu_busy, 0);
    #3 rst_n = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
